// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and the
// system clock / baud constants the baud-rate generator is built from.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEF_DATA_BITS   = 8;
  localparam int DEF_OVERSAMPLE  = 16;
  localparam int DEF_SYNC_STAGES = 2;

  localparam int CLK_HZ    = 50_000_000;
  localparam int BAUD_RATE = 115_200;

  // Rounded clk cycles between 16x ticks (27 for 50 MHz / 115200).
  localparam int BAUD_TICK_DIV =
    (CLK_HZ + (BAUD_RATE * DEF_OVERSAMPLE) / 2) / (BAUD_RATE * DEF_OVERSAMPLE);

  // Ticks from start detection to the stop-bit sample that delivers a byte.
  function automatic int frame_latency_ticks(input int oversample, input int data_bits);
    return oversample / 2 + oversample * (data_bits + 1);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-stage flop chain for bringing an asynchronous single-bit signal into clk.
// Every stage resets to RESET_VAL so no false edge appears when reset is released.
`timescale 1ns/1ps
module bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver. The FSM only moves on rx_tick enables; received
// bytes land in a valid/ack holding register with framing-error and overrun flags.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy,
  output uart_state_e          dbg_state
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic w_rxs;

  bit_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (rx),
    .o_q   (w_rxs)
  );

  uart_state_e          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;

  uart_state_e          w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_deliver;
  logic                 w_frame_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // STOP leaves at mid stop bit, so the next start edge can follow with no idle gap.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_deliver   = 1'b0;
    w_frame_bad = 1'b0;
    if (rx_tick) begin
      unique case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = START;
            w_cnt_nxt   = '0;
          end
        end
        START: begin
          if (r_cnt == HALF_LAST) begin
            w_cnt_nxt = '0;
            if (!w_rxs) begin
              w_state_nxt = DATA;
              w_idx_nxt   = '0;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (r_cnt == FULL_LAST) begin
            w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (r_cnt == FULL_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_deliver   = w_rxs;
            w_frame_bad = !w_rxs;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Holding register handshake: rx_valid rises when a byte is loaded and stays high
  // (rx_data frozen) until the clk edge that samples rx_ack=1; a load in the same
  // cycle as rx_ack keeps rx_valid high, a load onto an unacked byte sets overrun_err.
  logic                 r_pend;
  logic                 r_framing;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend    <= 1'b0;
      r_framing <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pend    <= w_deliver;
      r_framing <= w_frame_bad;
      if (r_pend) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        if (r_valid && !rx_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign framing_err = r_framing;
  assign overrun_err = r_overrun;
  // Pending delivery counts as busy so busy drops in the cycle rx_valid rises.
  assign busy        = (r_state != IDLE) || r_pend;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx: a tick generator, a serial frame driver,
// a delivery monitor and a scoreboard of expected bytes and delivery ticks.
`timescale 1ns/1ps
module tb_uart_rx;
  import uart_pkg::*;

  localparam int TICK_CLKS   = 28;
  localparam int OS          = DEF_OVERSAMPLE;
  localparam int DB          = DEF_DATA_BITS;
  localparam int BIT_CLKS    = TICK_CLKS * OS;
  localparam int LAT         = frame_latency_ticks(OS, DB);
  localparam int FRAME_TICKS = OS * (DB + 2);
  localparam int WAIT_BUDGET = 3 * FRAME_TICKS * TICK_CLKS;

  logic          clk;
  logic          reset;
  logic          rx_tick;
  logic          rx;
  logic          rx_ack;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          framing_err;
  logic          overrun_err;
  logic          busy;
  uart_state_e   dbg_state;

  uart_rx #(
    .DATA_BITS   (DB),
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (DEF_SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_tick     (rx_tick),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / tick / reset-independent timing ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    rx_tick = 1'b0;
    forever begin
      repeat (TICK_CLKS - 1) @(negedge clk);
      rx_tick = 1'b1;
      @(negedge clk);
      rx_tick = 1'b0;
    end
  end

  int tick_cnt = 0;
  int since    = 0;
  always @(posedge clk) begin
    if (rx_tick) begin
      tick_cnt <= tick_cnt + 1;
      since    <= 0;
    end else begin
      since <= since + 1;
    end
  end

  // ---------------- monitor ----------------
  typedef struct {
    logic [DB-1:0] data;
    int            tick;
    int            since;
    logic          busy;
  } obs_t;

  obs_t obs_q[$];
  logic prev_valid = 1'b0;
  int   fe_cycles  = 0;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) obs_q.push_back(obs_t'{rx_data, tick_cnt, since, busy});
    if (framing_err) fe_cycles <= fe_cycles + 1;
    prev_valid <= rx_valid;
  end

  // ---------------- scoreboard ----------------
  logic [DB-1:0] exp_q[$];
  int            exp_tick_q[$];
  int            obs_rd = 0;
  int            n_vec  = 0;
  int            n_err  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected delivery: detection on the tick after the start edge, then LAT ticks.
  task automatic expect_byte(input logic [DB-1:0] d, input int start_ref);
    exp_q.push_back(d);
    exp_tick_q.push_back(start_ref + 1 + LAT);
  endtask

  task automatic score(input string tag);
    logic [DB-1:0] e;
    int            et;
    obs_t          o;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      et = exp_tick_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        o = obs_q[obs_rd];
        obs_rd++;
        check({tag, "_data"}, o.data, e);
        check({tag, "_tick"}, o.tick, et);
        check({tag, "_clk_after_tick"}, o.since, 1);
        check({tag, "_busy_at_valid"}, o.busy, 1'b0);
      end else begin
        check({tag, "_delivery_count"}, obs_q.size(), obs_rd + 1);
      end
    end
    check({tag, "_no_extra_delivery"}, obs_q.size(), obs_rd);
    obs_rd = obs_q.size();
  endtask

  // ---------------- drivers ----------------
  task automatic align(output int n);
    do @(posedge clk); while (!rx_tick);
    @(negedge clk);
    n = tick_cnt;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * TICK_CLKS) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [DB-1:0] d, input logic stop_bit);
    logic [DB-1:0] v;
    v  = d;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = v[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic ack_n(input int n);
    int budget;
    for (int k = 0; k < n; k++) begin
      budget = 0;
      while (!rx_valid && budget < WAIT_BUDGET) begin
        @(negedge clk);
        budget++;
      end
      check("ack_wait_valid", rx_valid, 1'b1);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
    end
  endtask

  task automatic ack_at_tick(input int target);
    int budget;
    budget = 0;
    while (!(tick_cnt == target && since == 0) && budget < WAIT_BUDGET) begin
      @(negedge clk);
      budget++;
    end
    check("ack_at_tick_reached", tick_cnt, target);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    #(150_000 * 20);
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int            n;
    int            fe0;
    logic [DB-1:0] last_good;
    logic [DB-1:0] r0;
    logic [DB-1:0] r1;

    reset  = 1'b1;
    rx     = 1'b1;
    rx_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rx_data", rx_data, '0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_framing_err", framing_err, 1'b0);
    check("rst_overrun_err", overrun_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Single frame 0x55 with latency and busy/valid alignment.
    fe0 = fe_cycles;
    align(n);
    expect_byte(8'h55, n);
    fork
      drive_frame(8'h55, 1'b1);
      ack_n(1);
    join
    wait_ticks(4);
    score("s55");
    check("s55_no_framing", fe_cycles - fe0, 0);
    check("s55_overrun", overrun_err, 1'b0);

    // Back-to-back 0xA3, 0x0F with acks.
    align(n);
    expect_byte(8'hA3, n);
    expect_byte(8'h0F, n + FRAME_TICKS);
    fork
      begin
        drive_frame(8'hA3, 1'b1);
        drive_frame(8'h0F, 1'b1);
      end
      ack_n(2);
    join
    wait_ticks(4);
    score("b2b");
    check("b2b_overrun", overrun_err, 1'b0);
    last_good = 8'h0F;

    // Framing error: stop bit low.
    fe0 = fe_cycles;
    align(n);
    drive_frame(8'h3C, 1'b0);
    wait_ticks(20);
    check("fe_pulse_cycles", fe_cycles - fe0, 1);
    check("fe_rx_valid", rx_valid, 1'b0);
    check("fe_rx_data_kept", rx_data, last_good);
    check("fe_busy", busy, 1'b0);
    score("fe");

    // Four-tick glitch on the idle line, then 0x81.
    fe0 = fe_cycles;
    align(n);
    rx = 1'b0;
    repeat (4 * TICK_CLKS) @(negedge clk);
    rx = 1'b1;
    wait_ticks(12);
    check("glitch_busy", busy, 1'b0);
    check("glitch_state", dbg_state, IDLE);
    check("glitch_no_flags", fe_cycles - fe0, 0);
    check("glitch_rx_valid", rx_valid, 1'b0);
    score("glitch");
    align(n);
    expect_byte(8'h81, n);
    fork
      drive_frame(8'h81, 1'b1);
      ack_n(1);
    join
    wait_ticks(4);
    score("s81");

    // Overrun: 0x11 unacked, then 0x22.
    align(n);
    expect_byte(8'h11, n);
    drive_frame(8'h11, 1'b1);
    drive_frame(8'h22, 1'b1);
    wait_ticks(4);
    score("ovr");
    check("ovr_flag", overrun_err, 1'b1);
    check("ovr_rx_data", rx_data, 8'h22);
    check("ovr_rx_valid", rx_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_cleared_by_reset", overrun_err, 1'b0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Same again, acking in the exact delivery cycle of 0x22.
    align(n);
    expect_byte(8'h11, n);
    fork
      begin
        drive_frame(8'h11, 1'b1);
        drive_frame(8'h22, 1'b1);
      end
      ack_at_tick(n + FRAME_TICKS + 1 + LAT);
    join
    wait_ticks(4);
    score("ack_same");
    check("ack_same_overrun", overrun_err, 1'b0);
    check("ack_same_rx_data", rx_data, 8'h22);
    check("ack_same_rx_valid", rx_valid, 1'b1);
    ack_n(1);
    check("ack_clears_valid", rx_valid, 1'b0);

    // Reset in the middle of 0xFF data bits, then 0x5A.
    fe0 = fe_cycles;
    align(n);
    fork
      drive_frame(8'hFF, 1'b1);
      begin
        repeat (4 * BIT_CLKS + 100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_rx_data", rx_data, '0);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_state", dbg_state, IDLE);
        check("midrst_overrun", overrun_err, 1'b0);
        reset = 1'b0;
      end
    join
    wait_ticks(20);
    check("midrst_no_delivery", rx_valid, 1'b0);
    check("midrst_no_framing", fe_cycles - fe0, 0);
    score("midrst");
    align(n);
    expect_byte(8'h5A, n);
    fork
      drive_frame(8'h5A, 1'b1);
      ack_n(1);
    join
    wait_ticks(4);
    score("s5a");

    // Random bytes back-to-back.
    r0 = DB'($urandom_range(0, 255));
    r1 = DB'($urandom_range(0, 255));
    align(n);
    expect_byte(r0, n);
    expect_byte(r1, n + FRAME_TICKS);
    fork
      begin
        drive_frame(r0, 1'b1);
        drive_frame(r1, 1'b1);
      end
      ack_n(2);
    join
    wait_ticks(4);
    score("rand");
    check("rand_overrun", overrun_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
